// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: mode codes, FSM states and command classification for univ_shift_reg
// Optional feature macro: UNIV_SHIFT_REG_ASR_EN (mode 110 becomes a multi-cycle arithmetic shift right)
package univ_shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic {IDLE, SHIFT} state_e;

    // True for codes that run one position per clock; everything else completes on the accept edge.
    function automatic logic is_shift(input logic [2:0] m);
`ifdef UNIV_SHIFT_REG_ASR_EN
        return m inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR};
`else
        return m inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR};
`endif
    endfunction

    // Left-moving commands expel the MSB; all others (and the reset state) expel the LSB.
    function automatic logic is_left(input logic [2:0] m);
        return m inside {MODE_SHL, MODE_ROL};
    endfunction

endpackage

// File: rtl/univ_shift_reg_ctrl.sv
// univ_shift_reg_ctrl: command accept, shift FSM, clamped position counter, busy/done handshake
// Ports: clk, rst (async active-low), start/mode/amt command inputs;
//        accept (command taken this edge), shift_en (datapath moves one position this edge),
//        mode_q (latched shift mode), busy, done (one-cycle completion pulse)
// Optional feature macro: UNIV_SHIFT_REG_ASR_EN (via univ_shift_reg_pkg::is_shift)
module univ_shift_reg_ctrl
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amt,
    output logic             accept,
    output logic             shift_en,
    output logic [2:0]       mode_q,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_d;
    logic             done_q, done_d;

    assign busy     = state_q == SHIFT;
    assign shift_en = busy;
    assign accept   = start && !busy;
    assign done     = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start && is_shift(mode) && amt != '0) begin
                state_d = SHIFT;
                cnt_d   = (amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amt;
                mode_d  = mode;
            end else if (start) begin
                done_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with load, shift, rotate, clear and busy/done handshake
// Ports: clk, rst (async active-low), start/mode/amt/par_in command inputs, ser_in fill bit;
//        par_out register contents, ser_out next expelled bit, busy, done
// Optional feature macro: UNIV_SHIFT_REG_ASR_EN (mode 110 = arithmetic shift right)
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_in,
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    logic             accept, shift_en;
    logic [2:0]       mode_q;
    logic [WIDTH-1:0] reg_q, reg_d;

    univ_shift_reg_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .amt      (amt),
        .accept   (accept),
        .shift_en (shift_en),
        .mode_q   (mode_q),
        .busy     (busy),
        .done     (done)
    );

    always_comb begin
        reg_d = reg_q;
        if (accept && mode == MODE_LOAD) begin
            reg_d = par_in;
        end else if (accept && mode == MODE_CLR) begin
            reg_d = '0;
        end else if (shift_en) begin
            case (mode_q)
                MODE_SHL: reg_d = {reg_q[WIDTH-2:0], ser_in};
                MODE_SHR: reg_d = {ser_in, reg_q[WIDTH-1:1]};
                MODE_ROL: reg_d = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
                MODE_ROR: reg_d = {reg_q[0], reg_q[WIDTH-1:1]};
`ifdef UNIV_SHIFT_REG_ASR_EN
                MODE_ASR: reg_d = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
`endif
                default:  reg_d = reg_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) reg_q <= '0;
        else      reg_q <= reg_d;
    end

    assign par_out = reg_q;
    assign ser_out = is_left(mode_q) ? reg_q[WIDTH-1] : reg_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed self-checking bench for univ_shift_reg (WIDTH=4, CNT_W=3)
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] mode;
    logic [2:0] amt;
    logic [3:0] par_in;
    logic       ser_in;
    logic [3:0] par_out;
    logic       ser_out;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(4), .CNT_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .amt     (amt),
        .par_in  (par_in),
        .ser_in  (ser_in),
        .par_out (par_out),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] m, input logic [2:0] a, input logic [3:0] p, input logic s);
        start  = 1'b1;
        mode   = m;
        amt    = a;
        par_in = p;
        ser_in = s;
        tick();
        start  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; mode = 3'b000; amt = 3'd0; par_in = 4'h0; ser_in = 1'b0;
        #1;
        n_cmp++;
        if ({par_out, busy, done, ser_out} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_async: got par=%h busy=%b done=%b ser=%b want 0", par_out, busy, done, ser_out);
        end
        #11 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({par_out, busy, done, ser_out} !== 7'b0) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: got par=%h busy=%b done=%b ser=%b want 0", i, par_out, busy, done, ser_out);
            end
        end
    endtask

    task automatic test_load();
        issue(3'b001, 3'd0, 4'hA, 1'b0);
        n_cmp++;
        if ({par_out, busy, done} !== {4'hA, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL load_accept: got par=%h busy=%b done=%b want par=a busy=0 done=1", par_out, busy, done);
        end
        tick();
        n_cmp++;
        if ({par_out, busy, done} !== {4'hA, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL load_after: got par=%h busy=%b done=%b want par=a busy=0 done=0", par_out, busy, done);
        end
    endtask

    task automatic test_shl();
        logic [3:0] exp_par [3];
        logic       exp_busy [3];
        logic       exp_done [3];
        exp_par  = '{4'hA, 4'h5, 4'hB};
        exp_busy = '{1'b1, 1'b1, 1'b0};
        exp_done = '{1'b0, 1'b0, 1'b1};
        issue(3'b010, 3'd2, 4'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            n_cmp++;
            if ({par_out, busy, done, ser_out} !== {exp_par[i], exp_busy[i], exp_done[i], exp_par[i][3]}) begin
                n_err++;
                $display("FAIL shl[%0d]: got par=%h busy=%b done=%b ser=%b want par=%h busy=%b done=%b ser=%b",
                         i, par_out, busy, done, ser_out, exp_par[i], exp_busy[i], exp_done[i], exp_par[i][3]);
            end
        end
        tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL shl_done_once: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_ror_clamp_back_to_back();
        logic [3:0] exp_par [4];
        exp_par = '{4'hC, 4'h6, 4'h3, 4'h9};
        issue(3'b001, 3'd0, 4'h9, 1'b0);
        // Issued in the load's done cycle: busy=0, so it must be accepted.
        issue(3'b101, 3'd5, 4'h0, 1'b0);
        n_cmp++;
        if ({par_out, busy, done, ser_out} !== {4'h9, 1'b1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL ror_accept: got par=%h busy=%b done=%b ser=%b want par=9 busy=1 done=0 ser=1", par_out, busy, done, ser_out);
        end
        start = 1'b1; mode = 3'b001; par_in = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) start = 1'b0;
            tick();
            n_cmp++;
            if ({par_out, busy, done, ser_out} !== {exp_par[i], i != 3, i == 3, exp_par[i][0]}) begin
                n_err++;
                $display("FAIL ror[%0d]: got par=%h busy=%b done=%b ser=%b want par=%h busy=%b done=%b ser=%b",
                         i, par_out, busy, done, ser_out, exp_par[i], i != 3, i == 3, exp_par[i][0]);
            end
        end
        tick();
        n_cmp++;
        if ({par_out, busy, done} !== {4'h9, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL ror_final: got par=%h busy=%b done=%b want par=9 busy=0 done=0", par_out, busy, done);
        end
    endtask

    task automatic test_amt0();
        issue(3'b001, 3'd0, 4'h6, 1'b0);
        tick();
        issue(3'b010, 3'd0, 4'h0, 1'b1);
        n_cmp++;
        if ({par_out, busy, done} !== {4'h6, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL shl_amt0: got par=%h busy=%b done=%b want par=6 busy=0 done=1", par_out, busy, done);
        end
        tick();
        issue(3'b111, 3'd0, 4'hF, 1'b0);
        n_cmp++;
        if ({par_out, busy, done} !== {4'h0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL clr: got par=%h busy=%b done=%b want par=0 busy=0 done=1", par_out, busy, done);
        end
        tick();
    endtask

    task automatic test_mode6();
        issue(3'b001, 3'd0, 4'h8, 1'b0);
        tick();
        issue(3'b110, 3'd1, 4'h0, 1'b0);
`ifdef UNIV_SHIFT_REG_ASR_EN
        n_cmp++;
        if ({par_out, busy, done} !== {4'h8, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL asr_accept: got par=%h busy=%b done=%b want par=8 busy=1 done=0", par_out, busy, done);
        end
        tick();
        n_cmp++;
        if ({par_out, busy, done} !== {4'hC, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL asr_shift: got par=%h busy=%b done=%b want par=c busy=0 done=1", par_out, busy, done);
        end
`else
        n_cmp++;
        if ({par_out, busy, done} !== {4'h8, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL mode6_hold: got par=%h busy=%b done=%b want par=8 busy=0 done=1", par_out, busy, done);
        end
        tick();
        n_cmp++;
        if ({par_out, busy, done} !== {4'h8, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL mode6_after: got par=%h busy=%b done=%b want par=8 busy=0 done=0", par_out, busy, done);
        end
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        issue(3'b001, 3'd0, 4'hF, 1'b0);
        issue(3'b011, 3'd4, 4'h0, 1'b0);
        tick();
        tick();
        n_cmp++;
        if ({par_out, busy} !== {4'h3, 1'b1}) begin
            n_err++;
            $display("FAIL shr_mid: got par=%h busy=%b want par=3 busy=1", par_out, busy);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({par_out, busy, done, ser_out} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_mid_async: got par=%h busy=%b done=%b ser=%b want 0", par_out, busy, done, ser_out);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if ({par_out, busy, done} !== 6'b0) begin
                n_err++;
                $display("FAIL reset_mid_after[%0d]: got par=%h busy=%b done=%b want 0", i, par_out, busy, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shl();
        test_ror_clamp_back_to_back();
        test_amt0();
        test_mode6();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
